conv_filter_scheduler: RTL and testbench

//  Time-multiplexes K convolution filters onto U physical single-filter conv units (U <= K).

---
 rtl/conv_sched_pkg.sv | 37 +++
 rtl/conv_done_collector.sv | 32 +++
 rtl/conv_filter_scheduler.sv | 115 +++++++++++
 tb/tb_conv_filter_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared state encoding and sizing helpers for the conv filter scheduler
package conv_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_WAIT,
        S_STORE,
        S_FIN
    } state_t;

    typedef struct packed {
        logic [31:0] passes;
        logic [31:0] last_cnt;
    } pass_info_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Number of passes and how many units the final (possibly partial) pass occupies.
    function automatic pass_info_t pass_info(input int k, input int u);
        pass_info_t r;
        int p;
        p          = (k + u - 1) / u;
        r.passes   = 32'(p);
        r.last_cnt = 32'(k - (p - 1) * u);
        return r;
    endfunction

endpackage

// File: rtl/conv_done_collector.sv
// rtl/conv_done_collector.sv - sticky per-unit completion flags with valid masking
module conv_done_collector #(
    parameter int U = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         capture,
    input  logic [U-1:0] valid,
    input  logic [U-1:0] done_in,
    output logic         all_done
);

    logic [U-1:0] flags;
    logic [U-1:0] hits;

    assign hits = capture ? (done_in & valid) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags <= '0;
        end else if (clear) begin
            flags <= '0;
        end else begin
            flags <= flags | hits;
        end
    end

    // Same-cycle hits count so a unit finishing this cycle does not cost an extra WAIT cycle.
    assign all_done = ((flags | hits) & valid) == valid;

endmodule

// File: rtl/conv_filter_scheduler.sv
// rtl/conv_filter_scheduler.sv - time-multiplexes K filters onto U conv units in ceil(K/U) passes
module conv_filter_scheduler
    import conv_sched_pkg::*;
#(
    parameter int K     = 6,
    parameter int U     = 2,
    parameter int IDX_W = (clog2(K) < 1) ? 1 : clog2(K)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] filt_base,
    output logic [U-1:0]     unit_valid,
    output logic [U-1:0]     unit_start,
    input  logic [U-1:0]     unit_done,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_pass
);

    localparam pass_info_t       PI        = pass_info(K, U);
    localparam int               P         = int'(PI.passes);
    localparam int               LAST_CNT  = int'(PI.last_cnt);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(P - 1);
    localparam logic [IDX_W-1:0] STEP      = IDX_W'(U);
    localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);
    localparam logic [U-1:0]     FULL_MASK = '1;
    localparam logic [U-1:0]     LAST_MASK = U'((64'd1 << LAST_CNT) - 64'd1);

    state_t           state;
    state_t           state_n;
    logic [IDX_W-1:0] pass_q;
    logic [IDX_W-1:0] base_q;
    logic             all_done;
    logic             flags_clear;
    logic             flags_capture;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            pass_q <= '0;
            base_q <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && start) begin
                pass_q <= '0;
                base_q <= '0;
            end else if (state == S_STORE && pass_q != LAST_PASS) begin
                pass_q <= pass_q + ONE;
                base_q <= base_q + STEP;
            end
        end
    end

    always_comb begin
        state_n    = state;
        busy       = 1'b0;
        done       = 1'b0;
        wr_en      = 1'b0;
        unit_valid = '0;
        unit_start = '0;
        if (state != S_IDLE) begin
            unit_valid = (pass_q == LAST_PASS) ? LAST_MASK : FULL_MASK;
        end
        case (state)
            S_IDLE: begin
                if (start) state_n = S_LOAD;
            end
            S_LOAD: begin
                busy    = 1'b1;
                state_n = S_FIRE;
            end
            S_FIRE: begin
                busy       = 1'b1;
                unit_start = unit_valid;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (all_done) state_n = S_STORE;
            end
            S_STORE: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                state_n = (pass_q == LAST_PASS) ? S_FIN : S_LOAD;
            end
            S_FIN: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // A unit may finish in the very cycle it is started, so capture opens in FIRE.
    assign flags_clear   = (state == S_LOAD);
    assign flags_capture = (state == S_FIRE) || (state == S_WAIT);

    conv_done_collector #(
        .U(U)
    ) u_collector (
        .clk     (clk),
        .reset   (reset),
        .clear   (flags_clear),
        .capture (flags_capture),
        .valid   (unit_valid),
        .done_in (unit_done),
        .all_done(all_done)
    );

    assign filt_base = base_q;
    assign wr_pass   = pass_q;

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// tb/tb_conv_filter_scheduler.sv - directed-vector bench for conv_filter_scheduler
module tb_conv_filter_scheduler;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       start = 1'b0;
    logic [3:0] ud    = '0;
    int         sel   = 0;

    always #5 clk = ~clk;

    logic b0, dn0, we0; logic [2:0] fb0, wp0; logic [1:0] uv0, us0;
    logic b1, dn1, we1; logic [2:0] fb1, wp1; logic [1:0] uv1, us1;
    logic b2, dn2, we2; logic [2:0] fb2, wp2; logic [2:0] uv2, us2;
    logic b3, dn3, we3; logic [1:0] fb3, wp3; logic [3:0] uv3, us3;

    conv_filter_scheduler #(.K(6), .U(2)) dut0 (
        .clk(clk), .reset(rstn), .start(start && sel == 0), .busy(b0), .done(dn0),
        .filt_base(fb0), .unit_valid(uv0), .unit_start(us0), .unit_done(ud[1:0]),
        .wr_en(we0), .wr_pass(wp0));
    conv_filter_scheduler #(.K(5), .U(2)) dut1 (
        .clk(clk), .reset(rstn), .start(start && sel == 1), .busy(b1), .done(dn1),
        .filt_base(fb1), .unit_valid(uv1), .unit_start(us1), .unit_done(ud[1:0]),
        .wr_en(we1), .wr_pass(wp1));
    conv_filter_scheduler #(.K(6), .U(3)) dut2 (
        .clk(clk), .reset(rstn), .start(start && sel == 2), .busy(b2), .done(dn2),
        .filt_base(fb2), .unit_valid(uv2), .unit_start(us2), .unit_done(ud[2:0]),
        .wr_en(we2), .wr_pass(wp2));
    conv_filter_scheduler #(.K(4), .U(4)) dut3 (
        .clk(clk), .reset(rstn), .start(start && sel == 3), .busy(b3), .done(dn3),
        .filt_base(fb3), .unit_valid(uv3), .unit_start(us3), .unit_done(ud[3:0]),
        .wr_en(we3), .wr_pass(wp3));

    logic       busy_v, done_v, wr_v;
    logic [3:0] uv_v, us_v;
    logic [2:0] fb_v, wp_v;

    always_comb begin
        busy_v = b0; done_v = dn0; wr_v = we0;
        uv_v = {2'b0, uv0}; us_v = {2'b0, us0}; fb_v = fb0; wp_v = wp0;
        case (sel)
            1: begin
                busy_v = b1; done_v = dn1; wr_v = we1;
                uv_v = {2'b0, uv1}; us_v = {2'b0, us1}; fb_v = fb1; wp_v = wp1;
            end
            2: begin
                busy_v = b2; done_v = dn2; wr_v = we2;
                uv_v = {1'b0, uv2}; us_v = {1'b0, us2}; fb_v = fb2; wp_v = wp2;
            end
            3: begin
                busy_v = b3; done_v = dn3; wr_v = we3;
                uv_v = uv3; us_v = us3; fb_v = {1'b0, fb3}; wp_v = {1'b0, wp3};
            end
            default: ;
        endcase
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_list(input string tag, input int got[$], input int exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int all_outputs();
        return int'({busy_v, done_v, wr_v, uv_v, us_v, fb_v, wp_v});
    endfunction

    int wr_cyc[$], wr_ps[$], fire_fb[$], fire_uv[$], fire_us[$];
    int done_cyc, n_done, n_busy;

    // Cycle 0 is the IDLE cycle in which start is presented; dl[u] is the
    // number of cycles from a unit's start pulse to its one-cycle done pulse.
    task automatic run_layer(input int s, input int d0, input int d1, input int d2, input int d3,
                             input logic [3:0] force_hi, input bit hold, input int stop_at);
        int dl[4];
        int cnt[4];
        int cyc;
        dl  = '{d0, d1, d2, d3};
        cnt = '{-1, -1, -1, -1};
        sel = s;
        wr_cyc.delete(); wr_ps.delete(); fire_fb.delete(); fire_uv.delete(); fire_us.delete();
        done_cyc = -1; n_done = 0; n_busy = 0;
        start = 1'b1;
        ud    = force_hi;
        cyc   = 0;
        while (cyc < 300 && n_done == 0 && cyc != stop_at) begin
            tick();
            cyc++;
            if (!hold) start = 1'b0;
            if (busy_v) n_busy++;
            if (wr_v) begin
                wr_cyc.push_back(cyc);
                wr_ps.push_back(int'(wp_v));
            end
            if (us_v != 4'd0) begin
                fire_fb.push_back(int'(fb_v));
                fire_uv.push_back(int'(uv_v));
                fire_us.push_back(int'(us_v));
            end
            if (done_v) begin
                n_done++;
                done_cyc = cyc;
            end
            for (int u = 0; u < 4; u++) begin
                if (us_v[u]) cnt[u] = dl[u];
                ud[u] = force_hi[u] | (cnt[u] == 0);
                if (cnt[u] >= 0) cnt[u]--;
            end
        end
        ud = '0;
        if (stop_at < 0) begin
            check("layer_done", n_done, 1);
            if (!hold) begin
                tick();
                check("done_pulse_width", int'(done_v), 0);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            sel = i;
            #1;
            check($sformatf("reset_outputs_dut%0d", i), all_outputs(), 0);
        end
        rstn = 1'b1;
        tick();

        // K=6,U=2, each unit done 5 cycles after start: pass = 8 cycles
        run_layer(0, 5, 5, 0, 0, 4'b0000, 1'b0, -1);
        check_list("t1_wr_cyc", wr_cyc, '{8, 16, 24});
        check_list("t1_wr_pass", wr_ps, '{0, 1, 2});
        check_list("t1_filt_base", fire_fb, '{0, 2, 4});
        check_list("t1_unit_valid", fire_uv, '{3, 3, 3});
        check_list("t1_unit_start", fire_us, '{3, 3, 3});
        check("t1_done_cycle", done_cyc, 25);
        check("t1_busy_cycles", n_busy, 24);

        // K=5,U=2, unit 1 done held high; the last pass uses unit 0 only
        run_layer(1, 3, 3, 0, 0, 4'b0010, 1'b0, -1);
        check_list("t2_wr_cyc", wr_cyc, '{6, 12, 18});
        check_list("t2_wr_pass", wr_ps, '{0, 1, 2});
        check_list("t2_filt_base", fire_fb, '{0, 2, 4});
        check_list("t2_unit_valid", fire_uv, '{3, 3, 1});
        check_list("t2_unit_start", fire_us, '{3, 3, 1});
        check("t2_done_cycle", done_cyc, 19);

        // K=6,U=3, completion order unit 2, unit 0, unit 1
        run_layer(2, 4, 7, 1, 0, 4'b0000, 1'b0, -1);
        check_list("t3_wr_cyc", wr_cyc, '{10, 20});
        check_list("t3_wr_pass", wr_ps, '{0, 1});
        check_list("t3_filt_base", fire_fb, '{0, 3});
        check_list("t3_unit_valid", fire_uv, '{7, 7});
        check("t3_done_cycle", done_cyc, 21);

        // start held high for the whole layer and beyond
        run_layer(0, 2, 2, 0, 0, 4'b0000, 1'b1, -1);
        check_list("t4_wr_cyc", wr_cyc, '{5, 10, 15});
        check_list("t4_filt_base", fire_fb, '{0, 2, 4});
        check("t4_done_cycle", done_cyc, 16);
        tick();
        check("t4_idle_busy", int'(busy_v), 0);
        check("t4_idle_done", int'(done_v), 0);
        tick();
        check("t4_load_busy", int'(busy_v), 1);
        check("t4_load_unit_start", int'(us_v), 0);
        check("t4_load_filt_base", int'(fb_v), 0);
        tick();
        check("t4_fire_unit_start", int'(us_v), 3);
        start = 1'b0;
        rstn  = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // reset during pass 1 WAIT aborts the layer
        run_layer(0, 5, 5, 0, 0, 4'b0000, 1'b0, 12);
        check_list("t5_wr_cyc_before_reset", wr_cyc, '{8});
        check("t5_filt_base_before_reset", int'(fb_v), 2);
        rstn = 1'b0;
        tick();
        check("t5_outputs_after_reset", all_outputs(), 0);
        rstn = 1'b1;
        tick();
        tick();
        check("t5_stays_idle", int'(busy_v), 0);
        run_layer(0, 5, 5, 0, 0, 4'b0000, 1'b0, -1);
        check_list("t5_filt_base", fire_fb, '{0, 2, 4});
        check_list("t5_wr_pass", wr_ps, '{0, 1, 2});
        check("t5_done_cycle", done_cyc, 25);

        // K=4,U=4 with all units done in FIRE: IDLE, LOAD, FIRE, WAIT, STORE, FIN
        run_layer(3, 0, 0, 0, 0, 4'b0000, 1'b0, -1);
        check_list("t6_wr_cyc", wr_cyc, '{4});
        check_list("t6_wr_pass", wr_ps, '{0});
        check_list("t6_unit_valid", fire_uv, '{15});
        check_list("t6_unit_start", fire_us, '{15});
        check("t6_done_cycle", done_cyc, 5);
        check("t6_busy_cycles", n_busy, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
